// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Step-counter width for an arbitrary operand width; at least one bit.
  function automatic int cnt_width(input int w);
    return (w < 3) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// WIDTH-bit adder with carry-in, carry-out and two's-complement overflow.
module nibble_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] full;
  logic           c_msb;

  // Full-width add; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ full[WIDTH-1];
    ovf   = c_msb ^ full[WIDTH];
  end

endmodule

// File: rtl/seq_mult4.sv
// Sequential shift-add multiplier: one partial-product add per cycle,
// WIDTH steps per product, valid/ready on both sides.
// Optional build macro SEQ_MULT_SIGNED_EN selects two's-complement operation
// (arithmetic shift plus a subtract on the final step); default is unsigned.
module seq_mult4
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic             last;
  logic [WIDTH-1:0] addend;
  logic             ci;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             msb;
  logic             flag_unused;

  assign last = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  logic sub;

  // Signed step: the multiplier's sign bit carries negative weight, so the
  // final step subtracts mcand; the shifted-in bit is the true sum sign.
  always_comb begin
    sub         = last & mq[0];
    addend      = mq[0] ? (sub ? ~mcand : mcand) : '0;
    ci          = sub;
    msb         = sum[WIDTH-1] ^ ovf;
    flag_unused = cout;
  end
`else
  // Unsigned step: plain add, the carry-out becomes the new acc MSB.
  always_comb begin
    addend      = mq[0] ? mcand : '0;
    ci          = 1'b0;
    msb         = cout;
    flag_unused = ovf;
  end
`endif

  nibble_adder #(
    .WIDTH(WIDTH)
  ) u_add (
    .a    (acc),
    .b    (addend),
    .ci   (ci),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  assign p = {acc, mq};

  // Control FSM and shift registers; handshake outputs are registered decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mcand     <= '0;
      mq        <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            mq       <= b;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          acc <= {msb, sum[WIDTH-1:1]};
          mq  <= {sum[0], mq[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_mult4.md
# seq_mult4

Sequential shift-add multiplier built around one WIDTH-bit adder stage: accepts two WIDTH-bit operands over a valid/ready handshake, iterates one partial-product add per cycle, and returns a 2*WIDTH-bit product. It sits directly downstream of the operand source and reuses the team's ripple/look-ahead adder as its datapath, consuming the adder's sum and carry-out every cycle.

## Interface
- WIDTH, 4, operand width in bits (legal 2..16)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  2*WIDTH  product, held stable while out_valid=1

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: mcand<=a, mq<=b, acc<=0, cnt<=0, go RUN.
- RUN, each cycle: addend = mq[0] ? mcand : 0; {c,sum} = acc + addend (adder, ci=0); {acc,mq} <= {c,sum,mq} >> 1; cnt<=cnt+1. After step cnt==WIDTH-1 go DONE.
- DONE: out_valid=1, p={acc,mq}. On out_ready go IDLE. No acceptance of new operands in DONE, even if out_ready=1 the same cycle.
- in_valid while not IDLE is ignored; a/b sampled only on the accept cycle.
- Operand changes after accept have no effect.
- Arithmetic: unsigned by default; product never overflows 2*WIDTH bits; carry-out of each step is the new acc MSB.
- Zero operand: still runs full WIDTH steps (no early termination).
- Reset any time (including mid-RUN or DONE with out_ready=0): next cycle state=IDLE, all registers cleared, in-flight result discarded.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, p=0.
- Accept at cycle T; RUN for cycles T+1..T+WIDTH; out_valid=1 from cycle T+WIDTH+1.
- Latency accept→out_valid: WIDTH+1 cycles (5 for WIDTH=4).
- Minimum issue interval: WIDTH+2 cycles (DONE one cycle with out_ready=1, then IDLE).
- out_valid stays high and p stable indefinitely until out_ready sampled high.
- in_ready and out_valid are registered state decodes; never both high.

## Configuration
- SEQ_MULT_SIGNED_EN defined: two's-complement operands/product. Each RUN step shifts right arithmetically with sign = sum[WIDTH-1] ^ overflow (adder carry into vs out of MSB). On the final step (cnt==WIDTH-1) with mq[0]=1 the adder computes acc + ~mcand with ci=1 (subtract) instead of add.
- Not defined: unsigned only, logical shift with adder carry-out as MSB, adder ci tied 0; no subtract path synthesised.
- Latency and handshake identical in both builds.

## Structure
- Package mult_pkg: state enum (IDLE, RUN, DONE), default WIDTH constant, count-width localparam ($clog2(WIDTH)).
- One sub-module: nibble_adder (WIDTH-bit adder with ci, cout, and overflow outputs), instanced once; control FSM and shift registers in seq_mult4.

## Test plan
- Unsigned: a=4'hF, b=4'hF, out_ready=1 → out_valid exactly 5 cycles after accept, p=8'hE1; in_ready returns 1 one cycle later.
- Unsigned: a=4'h7, b=4'h3 → p=8'h15; a=4'h0, b=4'hB → p=8'h00 with same 5-cycle latency; a=4'h8, b=4'h9 → p=8'h48.
- Backpressure: a=4'h5, b=4'h6, out_ready=0 for 10 cycles → out_valid held, p=8'h1E stable, in_valid pulses ignored (in_ready=0); release → one transfer, then IDLE.
- Reset mid-op: accept 4'hF×4'hF, assert rst on second RUN cycle → next cycle in_ready=1, out_valid=0, p=0; subsequent 4'h2×4'h3 → p=8'h06.
- SEQ_MULT_SIGNED_EN build: a=4'h8 (-8), b=4'h8 (-8) → p=8'h40; a=4'h8, b=4'h7 → p=8'hC8 (-56); a=4'hF (-1), b=4'h1 → p=8'hFF.
- Back-to-back: in_valid held high with random operands for 50 products vs. reference model → all match, issue interval exactly 6 cycles.
